// File: rtl/sha256_ctrl_pkg.sv
// Shared types and constants for the SHA-256 host controller: FSM states,
// host command codes, status bit positions and the fixed uio output enable.
package sha256_ctrl_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ctrl_state_t;

  localparam logic [1:0] CMD_DATA        = 2'b00;
  localparam logic [1:0] CMD_START_FIRST = 2'b01;
  localparam logic [1:0] CMD_START_NEXT  = 2'b10;
  localparam logic [1:0] CMD_ABORT       = 2'b11;

  localparam int STAT_BUSY         = 0;
  localparam int STAT_BUF_FULL     = 1;
  localparam int STAT_DIGEST_VALID = 2;
  localparam int STAT_ERR          = 3;

  localparam logic [7:0] HOST_OE = 8'hF0;

  // Byte 0 is the most significant byte of the digest word.
  function automatic logic [7:0] digest_byte(input logic [31:0] word, input logic [1:0] sel);
    logic [7:0] b;
    case (sel)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sha256_host_ctrl_sync_edge.sv
// Multi-flop synchroniser for an asynchronous host strobe followed by a
// rising-edge detector; rise is high for one cycle, SYNC_STAGES+1 edges after the pin.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      last_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/sha256_host_ctrl.sv
// Byte-serial host controller for the SHA-256 core: message load, start/done
// sequencing and digest readback. Build option SHA256_AUTOSTART_EN starts the core on word 15.
//
// state | meaning
// LOAD  | accepting message bytes, buffer not yet handed to the core
// RUN   | core compressing; host writes are errors, reads ignored
// DONE  | digest readable; a DATA byte begins the next block
module sha256_host_ctrl
  import sha256_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int BLOCK_WORDS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic [7:0]  host_din,
  input  logic        host_wr,
  input  logic        host_rd,
  input  logic [1:0]  host_cmd,
  output logic [7:0]  host_dout,
  output logic [3:0]  host_status,
  output logic [7:0]  host_oe,
  output logic [31:0] msg_word,
  output logic [3:0]  msg_idx,
  output logic        msg_we,
  output logic        core_start,
  output logic        core_first,
  input  logic        core_busy,
  input  logic        core_done,
  output logic [2:0]  digest_idx,
  input  logic [31:0] digest_word
);

  localparam logic [6:0] BUF_BYTES = 7'(BLOCK_WORDS * 4);

  ctrl_state_t state;
  logic [6:0]  byte_ptr;
  logic [4:0]  rd_ptr;
  logic        digest_valid, first_pending, abort_pending, err;
  logic        wr_rise, rd_rise, wr_edge, rd_edge;
  logic        buf_full, wr_abort, go_run;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_wr (
    .clk(clk), .rst_n(rst_n), .din(host_wr), .rise(wr_rise));
  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rd (
    .clk(clk), .rst_n(rst_n), .din(host_rd), .rise(rd_rise));

  assign wr_edge  = wr_rise & ena;
  assign rd_edge  = rd_rise & ena;
  assign buf_full = (byte_ptr == BUF_BYTES);
  assign wr_abort = wr_edge && (host_cmd == CMD_ABORT) && (state != RUN);

  // go_run marks the write edge that hands the buffer to the core.
`ifdef SHA256_AUTOSTART_EN
  assign go_run = wr_edge && (state != RUN) && (host_cmd == CMD_DATA) &&
                  (byte_ptr == BUF_BYTES - 7'd1);
`else
  assign go_run = wr_edge && (state != RUN) && buf_full &&
                  ((host_cmd == CMD_START_FIRST) || (host_cmd == CMD_START_NEXT));
`endif

  assign host_oe    = HOST_OE;
  assign digest_idx = rd_ptr[4:2];

  always_comb begin
    host_status                    = '0;
    host_status[STAT_BUSY]         = (state == RUN);
    host_status[STAT_BUF_FULL]     = buf_full;
    host_status[STAT_DIGEST_VALID] = digest_valid;
    host_status[STAT_ERR]          = err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= LOAD;
      byte_ptr      <= '0;
      rd_ptr        <= '0;
      digest_valid  <= 1'b0;
      first_pending <= 1'b1;
      abort_pending <= 1'b0;
      err           <= 1'b0;
      host_dout     <= '0;
      msg_word      <= '0;
      msg_idx       <= '0;
      msg_we        <= 1'b0;
      core_start    <= 1'b0;
      core_first    <= 1'b0;
    end else begin
      msg_we     <= 1'b0;
      core_start <= 1'b0;
      host_dout  <= digest_valid ? digest_byte(digest_word, rd_ptr[1:0]) : 8'h00;

      if (wr_edge) begin
        if (state == RUN) begin
          if (host_cmd == CMD_ABORT) abort_pending <= 1'b1;
          else                       err <= 1'b1;
        end else begin
          case (host_cmd)
            CMD_DATA: begin
              if (buf_full) begin
                err <= 1'b1;
              end else begin
                msg_word <= {msg_word[23:0], host_din};
                byte_ptr <= byte_ptr + 7'd1;
                state    <= LOAD;
                if (byte_ptr[1:0] == 2'd3) begin
                  msg_we  <= 1'b1;
                  msg_idx <= byte_ptr[5:2];
                end
              end
            end
            CMD_START_FIRST, CMD_START_NEXT: begin
              if (!go_run) err <= 1'b1;
            end
            default: begin
              byte_ptr      <= '0;
              rd_ptr        <= '0;
              digest_valid  <= 1'b0;
              first_pending <= 1'b1;
              err           <= 1'b0;
              state         <= LOAD;
            end
          endcase
          if (go_run) begin
            core_start   <= 1'b1;
            core_first   <= (host_cmd == CMD_START_FIRST) | first_pending;
            digest_valid <= 1'b0;
            state        <= RUN;
          end
        end
      end

      // Reads see the state left by a same-cycle write.
      if (rd_edge && (state != RUN) && !go_run) begin
        if (digest_valid && !wr_abort) rd_ptr <= rd_ptr + 5'd1;
        else                           err <= 1'b1;
      end

      if (core_done && (state == RUN)) begin
        byte_ptr      <= '0;
        rd_ptr        <= '0;
        abort_pending <= 1'b0;
        if (abort_pending || (wr_edge && (host_cmd == CMD_ABORT))) begin
          digest_valid  <= 1'b0;
          first_pending <= 1'b1;
          err           <= 1'b0;
          state         <= LOAD;
        end else begin
          digest_valid  <= 1'b1;
          first_pending <= 1'b0;
          state         <= DONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_sha256_host_ctrl.sv
// Directed self-checking bench for sha256_host_ctrl with a simple core model
// (fixed 65-cycle latency, digest bytes H[i] byte k = 8'hA0 + 4*i + k).
module tb_sha256_host_ctrl;
  import sha256_ctrl_pkg::*;

  localparam int CORE_LAT = 65;

  logic        clk = 1'b0;
  logic        rst_n, ena;
  logic [7:0]  host_din;
  logic        host_wr, host_rd;
  logic [1:0]  host_cmd;
  logic [7:0]  host_dout;
  logic [3:0]  host_status;
  logic [7:0]  host_oe;
  logic [31:0] msg_word;
  logic [3:0]  msg_idx;
  logic        msg_we, core_start, core_first;
  logic        core_busy, core_done;
  logic [2:0]  digest_idx;
  logic [31:0] digest_word;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          we_cnt   = 0;
  int          start_cnt = 0;
  logic        last_first = 1'b0;
  logic [3:0]  last_idx = '0;
  logic [15:0] idx_mask = '0;
  logic [31:0] words [16];

  sha256_host_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .host_din(host_din), .host_wr(host_wr),
    .host_rd(host_rd), .host_cmd(host_cmd), .host_dout(host_dout),
    .host_status(host_status), .host_oe(host_oe), .msg_word(msg_word),
    .msg_idx(msg_idx), .msg_we(msg_we), .core_start(core_start),
    .core_first(core_first), .core_busy(core_busy), .core_done(core_done),
    .digest_idx(digest_idx), .digest_word(digest_word));

  always #5 clk = ~clk;

  assign digest_word = 32'hA0A1A2A3 + {29'd0, digest_idx} * 32'h04040404;

  always @(negedge clk) begin
    if (msg_we) begin
      we_cnt++;
      words[msg_idx] = msg_word;
      last_idx = msg_idx;
      idx_mask = idx_mask | (16'd1 << msg_idx);
    end
    if (core_start) begin
      start_cnt++;
      last_first = core_first;
    end
  end

  initial begin
    core_busy = 1'b0;
    core_done = 1'b0;
    forever begin
      @(negedge clk);
      if (core_start && rst_n) begin
        core_busy = 1'b1;
        for (int i = 0; i < CORE_LAT && rst_n; i++) @(negedge clk);
        if (rst_n) begin
          core_done = 1'b1;
          @(negedge clk);
          core_done = 1'b0;
        end
        core_busy = 1'b0;
      end
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr_cmd(input logic [1:0] cmd, input logic [7:0] din);
    @(negedge clk);
    host_cmd = cmd;
    host_din = din;
    host_wr  = 1'b1;
    repeat (5) @(negedge clk);
    host_wr = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic rd_strobe();
    @(negedge clk);
    host_rd = 1'b1;
    repeat (5) @(negedge clk);
    host_rd = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic load_bytes(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) wr_cmd(CMD_DATA, base + 8'(i));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_digest();
    for (int i = 0; i < 300 && !host_status[STAT_DIGEST_VALID]; i++) @(negedge clk);
    @(negedge clk);
  endtask

  int we0, st0;

  initial begin
    rst_n = 1'b0; ena = 1'b1; host_din = '0; host_wr = 1'b0; host_rd = 1'b0; host_cmd = CMD_DATA;
    repeat (3) @(negedge clk);
    chk("rst_status", host_status, 4'h0);
    chk("rst_oe", host_oe, 8'hF0);
    chk("rst_dout", host_dout, 8'h00);
    chk("rst_start_we", {core_start, msg_we, core_first}, 3'b000);
    chk("rst_idx", {msg_idx, digest_idx}, 7'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // read with no digest
    rd_strobe();
    chk("rd_nodigest_dout", host_dout, 8'h00);
    chk("rd_nodigest_status", host_status, 4'b1000);
    wr_cmd(CMD_ABORT, 8'h00);
    chk("abort_clr_err", host_status, 4'b0000);

    // first block
    idx_mask = '0; we0 = we_cnt;
    load_bytes(8'h00, 64);
    chk("blk1_we_cnt", we_cnt - we0, 16);
    chk("blk1_idx_mask", idx_mask, 16'hFFFF);
    chk("blk1_word0", words[0], 32'h00010203);
    chk("blk1_word15", words[15], 32'h3C3D3E3F);
    chk("blk1_status_full", host_status, 4'b0010);
    st0 = start_cnt;
    wr_cmd(CMD_START_FIRST, 8'h00);
    chk("sf_one_start", start_cnt - st0, 1);
    chk("sf_first", last_first, 1'b1);
    chk("sf_busy_status", host_status, 4'b0011);
    wait_digest();
    chk("blk1_done_status", host_status, 4'b0100);
    chk("blk1_no_restart", start_cnt - st0, 1);

    for (int p = 0; p < 32; p++) begin
      chk($sformatf("rd_byte%0d", p), host_dout, 8'hA0 + 8'(p));
      rd_strobe();
    end
    chk("rd_wrap", host_dout, 8'hA0);

    // second block, chained
    idx_mask = '0;
    load_bytes(8'h40, 64);
    chk("blk2_word0", words[0], 32'h40414243);
    chk("blk2_word15", words[15], 32'h7C7D7E7F);
    st0 = start_cnt;
    wr_cmd(CMD_START_NEXT, 8'h00);
    chk("sn_one_start", start_cnt - st0, 1);
    chk("sn_first", last_first, 1'b0);
    wait_digest();
    chk("blk2_done_status", host_status, 4'b0100);

    // partial buffer start, overflow, abort
    wr_cmd(CMD_ABORT, 8'h00);
    chk("abort_done_status", host_status, 4'b0000);
    load_bytes(8'h00, 60);
    st0 = start_cnt;
    wr_cmd(CMD_START_FIRST, 8'h00);
    chk("short_no_start", start_cnt - st0, 0);
    chk("short_err", host_status, 4'b1000);
    load_bytes(8'h3C, 4);
    chk("full_err_status", host_status, 4'b1010);
    we0 = we_cnt;
    wr_cmd(CMD_DATA, 8'hEE);
    chk("ovf_no_we", we_cnt - we0, 0);
    chk("ovf_status", host_status, 4'b1010);
    wr_cmd(CMD_ABORT, 8'h00);
    chk("ovf_abort_status", host_status, 4'b0000);
    load_bytes(8'h10, 4);
    chk("abort_ptr0_idx", last_idx, 4'd0);
    chk("abort_ptr0_word", words[0], 32'h10111213);

    // reset while msg_we is high
    do_reset();
    load_bytes(8'h20, 3);
    @(negedge clk);
    host_cmd = CMD_DATA; host_din = 8'h23; host_wr = 1'b1;
    for (int i = 0; i < 20 && !msg_we; i++) @(negedge clk);
    chk("midload_we_seen", msg_we, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("midload_rst_we", {msg_we, msg_idx}, 5'd0);
    chk("midload_rst_word", msg_word, 32'h0);
    chk("midload_rst_oe", host_oe, 8'hF0);
    host_wr = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // reset while core_start is high
    load_bytes(8'h00, 64);
    @(negedge clk);
    host_cmd = CMD_START_FIRST; host_wr = 1'b1;
    for (int i = 0; i < 20 && !core_start; i++) @(negedge clk);
    chk("midrun_start_seen", core_start, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrun_rst_start", core_start, 1'b0);
    chk("midrun_rst_status", host_status, 4'h0);
    chk("midrun_rst_oe", host_oe, 8'hF0);
    host_wr = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // START_NEXT straight after reset, then DATA and ABORT during RUN
    load_bytes(8'h00, 64);
    st0 = start_cnt;
    wr_cmd(CMD_START_NEXT, 8'h00);
    chk("sn_after_rst_start", start_cnt - st0, 1);
    chk("sn_after_rst_first", last_first, 1'b1);
    we0 = we_cnt;
    wr_cmd(CMD_DATA, 8'h55);
    chk("run_data_no_we", we_cnt - we0, 0);
    chk("run_data_err", host_status, 4'b1011);
    wr_cmd(CMD_ABORT, 8'h00);
    for (int i = 0; i < 200 && core_busy; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("run_abort_status", host_status, 4'b0000);
    chk("run_abort_dout", host_dout, 8'h00);

    // design not selected
    ena = 1'b0;
    we0 = we_cnt;
    load_bytes(8'h00, 4);
    rd_strobe();
    chk("ena0_no_we", we_cnt - we0, 0);
    chk("ena0_status", host_status, 4'b0000);
    ena = 1'b1;
    load_bytes(8'hA8, 4);
    chk("ena1_word0", words[0], 32'hA8A9AAAB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
